// File: rtl/temp_calc_mc_if.sv
// Sample/result bus of the multi-channel temperature calculator.
// master = sensor-side driver and house controller, slave = temp_calc_mc.
interface temp_calc_mc_if #(
  parameter int CH    = 4,
  parameter int CH_W  = 2,
  parameter int ADC_W = 16,
  parameter int REF_W = 8,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_ch;
  logic [OUT_W-1:0] tc_base;
  logic [REF_W-1:0] tc_ref;
  logic [ADC_W-1:0] adc_data;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic [OUT_W-1:0] tempc;
  logic [CH-1:0]    drd;
  logic [CH-1:0]    drd_clr;

  modport master (
    output in_valid, in_ch, tc_base, tc_ref, adc_data, drd_clr,
    input  in_ready, out_valid, out_ch, tempc, drd
  );

  modport slave (
    input  in_valid, in_ch, tc_base, tc_ref, adc_data, drd_clr,
    output in_ready, out_valid, out_ch, tempc, drd
  );
endinterface

// File: rtl/temp_calc_mc.sv
// Multi-channel temperature calculator:
//   tempc = tc_base + ((adc_data * tc_ref) >> FRAC), shift-add multiplier,
//   one sample in flight, sticky per-channel data-ready flags.
// Optional per-channel two-sample averaging is enabled by TEMP_CALC_AVG_EN.
module temp_calc_mc #(
  parameter int CH    = 4,
  parameter int CH_W  = 2,
  parameter int ADC_W = 16,
  parameter int REF_W = 8,
  parameter int OUT_W = 32,
  parameter int FRAC  = 4
) (
  input logic           clk,
  input logic           rst,
  temp_calc_mc_if.slave bus
);
  localparam int PROD_W = ADC_W + REF_W;
  localparam int CNT_W  = $clog2(REF_W + 1);
  localparam int IDX_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH);

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic [PROD_W-1:0] acc_reg;
  logic [PROD_W-1:0] mcand_reg;
  logic [REF_W-1:0]  mplier_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [OUT_W-1:0]  base_reg;
  logic [CH_W-1:0]   ch_reg;
  logic              out_valid_reg;
  logic [CH_W-1:0]   out_ch_reg;
  logic [OUT_W-1:0]  tempc_reg;
  logic [CH-1:0]     drd_reg;
  logic [CH-1:0]     drd_next;

  logic              ch_ok;
  logic [IDX_W-1:0]  ch_idx;
  logic [PROD_W-1:0] prod_shifted;
  logic [OUT_W-1:0]  raw;
  logic [OUT_W-1:0]  result;

  // Samples addressed to a non-existent channel are swallowed in IDLE.
  assign ch_ok        = ({1'b0, bus.in_ch} < CH_LIM);
  assign ch_idx       = IDX_W'(ch_reg);
  assign prod_shifted = acc_reg >> FRAC;
  assign raw          = base_reg + OUT_W'(prod_shifted);

`ifdef TEMP_CALC_AVG_EN
  logic [OUT_W-1:0] hist_reg [CH];
  logic [CH-1:0]    hist_vld_reg;
  logic [OUT_W:0]   avg_sum;

  // One extra bit keeps the two-sample sum from wrapping before the halving.
  assign avg_sum = {1'b0, hist_reg[ch_idx]} + {1'b0, raw};
  assign result  = hist_vld_reg[ch_idx] ? OUT_W'(avg_sum >> 1) : raw;

  // History holds the un-averaged value of the channel's previous sample.
  always_ff @(posedge clk) begin
    if (state_reg == ADD) hist_reg[ch_idx] <= raw;
  end

  // History validity is the only part of the history that reset touches.
  always_ff @(posedge clk) begin
    if (rst) hist_vld_reg <= '0;
    else if (state_reg == ADD) hist_vld_reg[ch_idx] <= 1'b1;
  end
`else
  assign result = raw;
`endif

  // Control FSM, multiplier datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      tempc_reg     <= '0;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      cnt_reg       <= '0;
      base_reg      <= '0;
      ch_reg        <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && ch_ok) begin
            acc_reg      <= '0;
            mcand_reg    <= PROD_W'(bus.adc_data);
            mplier_reg   <= bus.tc_ref;
            base_reg     <= bus.tc_base;
            ch_reg       <= bus.in_ch;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= MUL;
          end
        end
        MUL: begin
          // One multiplier bit per cycle, LSB first, never exits early.
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(REF_W - 1)) state_reg <= ADD;
        end
        ADD: begin
          tempc_reg     <= result;
          out_ch_reg    <= ch_reg;
          out_valid_reg <= 1'b1;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          in_ready_reg <= 1'b1;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  // Per-channel sticky flag: completing a result sets it and beats a clear.
  for (genvar gi = 0; gi < CH; gi++) begin : g_drd
    assign drd_next[gi] = ((state_reg == ADD) && (ch_idx == IDX_W'(gi))) ? 1'b1 :
                          (bus.drd_clr[gi] ? 1'b0 : drd_reg[gi]);
  end

  // Data-ready flag register.
  always_ff @(posedge clk) begin
    if (rst) drd_reg <= '0;
    else     drd_reg <= drd_next;
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.tempc     = tempc_reg;
  assign bus.drd       = drd_reg;
endmodule

// File: tb/tb_temp_calc_mc.sv
// Self-checking bench for temp_calc_mc: arithmetic reference model plus
// directed and randomized stimulus. Channel index is 3 bits wide here so
// out-of-range channels can be offered.
module tb_temp_calc_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;

  temp_calc_mc_if #(.CH(4), .CH_W(3), .ADC_W(16), .REF_W(8), .OUT_W(32)) bus ();

  temp_calc_mc #(.CH(4), .CH_W(3), .ADC_W(16), .REF_W(8), .OUT_W(32), .FRAC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          edge_n = 0;
  bit          chk_en = 0;
  bit          m_ready = 1'b1;
  bit          m_valid = 1'b0;
  logic [2:0]  m_ch = '0;
  logic [31:0] m_tempc = '0;
  logic [3:0]  m_drd = '0;
  bit          pend_vld = 1'b0;
  int          pend_due = 0;
  logic [2:0]  pend_ch = '0;
  logic [31:0] pend_raw = '0;
  logic [31:0] hist_m [4];
  bit   [3:0]  hist_vld_m = '0;
  logic [63:0] m_prod;
  logic [32:0] m_sum;

  // Predicts the outputs present after each rising edge.
  always @(posedge clk) begin
    edge_n++;
    m_valid = 1'b0;
    if (rst) begin
      chk_en     = 1'b1;
      m_ready    = 1'b1;
      m_ch       = '0;
      m_tempc    = '0;
      m_drd      = '0;
      pend_vld   = 1'b0;
      hist_vld_m = '0;
    end else begin
      m_drd = m_drd & ~bus.drd_clr;
      if (pend_vld && edge_n == pend_due) begin
        m_tempc = pend_raw;
`ifdef TEMP_CALC_AVG_EN
        if (hist_vld_m[pend_ch[1:0]]) begin
          m_sum   = {1'b0, hist_m[pend_ch[1:0]]} + {1'b0, pend_raw};
          m_tempc = m_sum[32:1];
        end
        hist_m[pend_ch[1:0]]     = pend_raw;
        hist_vld_m[pend_ch[1:0]] = 1'b1;
`endif
        m_valid              = 1'b1;
        m_ch                 = pend_ch;
        m_drd[pend_ch[1:0]]  = 1'b1;
        pend_vld             = 1'b0;
        m_ready              = 1'b1;
      end else if (m_ready && bus.in_valid && bus.in_ch < 3'd4) begin
        m_prod   = 64'(bus.adc_data) * 64'(bus.tc_ref);
        pend_raw = 32'(64'(bus.tc_base) + (m_prod >> 4));
        pend_ch  = bus.in_ch;
        pend_due = edge_n + 9;
        pend_vld = 1'b1;
        m_ready  = 1'b0;
      end
    end
  end

  // Compare DUT outputs with the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(bus.in_ready), 64'(m_ready));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("drd", 64'(bus.drd), 64'(m_drd));
      check("tempc", 64'(bus.tempc), 64'(m_tempc));
      check("out_ch", 64'(bus.out_ch), 64'(m_ch));
    end
  end

  // Result log and pulse counter, sampled mid-cycle.
  int pulse_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (bus.out_valid) begin
      pulse_cnt++;
      $display("result: ch=%0d tempc=%08h drd=%04b", bus.out_ch, bus.tempc, bus.drd);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offers one sample and returns at the falling edge after its handshake.
  task automatic send(input logic [2:0] ch, input logic [31:0] base, input logic [7:0] rf,
                      input logic [15:0] adc, output int hs_edge);
    int n = 0;
    @(negedge clk);
    bus.in_ch    = ch;
    bus.tc_base  = base;
    bus.tc_ref   = rf;
    bus.adc_data = adc;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("send_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    hs_edge = edge_n;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int e, output logic [31:0] t, output logic [2:0] c);
    int n = 0;
    e = 0; t = '0; c = '0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check("result_timeout", 64'(n), 64'(0));
    e = edge_n;
    t = bus.tempc;
    c = bus.out_ch;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int hs, re, p0, lowc;
    logic [31:0] t;
    logic [2:0]  c;
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.tc_base  = '0;
    bus.tc_ref   = '0;
    bus.adc_data = '0;
    bus.drd_clr  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_drd", 64'(bus.drd), 64'(0));
    check("reset_tempc", 64'(bus.tempc), 64'(0));

    // Basic: 8 + (8*16 >> 4) = 16, nine edges after the handshake.
    send(3'd0, 32'd8, 8'd16, 16'd8, hs);
    wait_result(re, t, c);
    check("basic_latency", 64'(re - hs), 64'(9));
    check("basic_tempc", 64'(t), 64'(16));
    check("basic_ch", 64'(c), 64'(0));
    check("basic_drd", 64'(bus.drd), 64'(4'b0001));
    @(negedge clk);
    check("basic_pulse_1cyc", 64'(bus.out_valid), 64'(0));

    // Wrap-around of the final addition.
    send(3'd2, 32'hFFFF_FFF0, 8'hFF, 16'hFFFF, hs);
    wait_result(re, t, c);
    check("wrap_tempc", 64'(t), 64'h000F_EFE0);
    check("wrap_drd2", 64'(bus.drd[2]), 64'(1));

    // Backpressure: ch1 held valid while busy.
    p0 = pulse_cnt;
    send(3'd0, 32'd1, 8'd3, 16'd32, hs);
    bus.in_ch = 3'd1; bus.tc_base = 32'd5; bus.tc_ref = 8'd2; bus.adc_data = 16'd64;
    bus.in_valid = 1'b1;
    lowc = 0;
    while (!bus.in_ready && lowc < 40) begin
      lowc++;
      @(negedge clk);
    end
    check("bp_busy_cycles", 64'(lowc), 64'(9));
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("bp_pulses", 64'(pulse_cnt - p0), 64'(2));
    check("bp_last_tempc", 64'(bus.tempc), 64'(13));

    // Reset four edges into MUL aborts the computation.
    send(3'd3, 32'd7, 8'd9, 16'd11, hs);
    repeat (3) @(negedge clk);
    p0 = pulse_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_drd", 64'(bus.drd), 64'(0));
    repeat (15) @(negedge clk);
    check("abort_no_result", 64'(pulse_cnt - p0), 64'(0));

    // Out-of-range channel is consumed without a result.
    p0 = pulse_cnt;
    send(3'd5, 32'd1, 8'd1, 16'd1, hs);
    check("badch_ready", 64'(bus.in_ready), 64'(1));
    repeat (12) @(negedge clk);
    check("badch_no_result", 64'(pulse_cnt - p0), 64'(0));

    // Set beats clear on the same edge; clear alone works on the next.
    send(3'd0, 32'd3, 8'd0, 16'd9, hs);
    while (edge_n < hs + 8) @(negedge clk);
    bus.drd_clr = 4'b0001;
    @(negedge clk);
    check("setclr_valid", 64'(bus.out_valid), 64'(1));
    check("setclr_drd0", 64'(bus.drd[0]), 64'(1));
    @(negedge clk);
    check("clr_drd0", 64'(bus.drd[0]), 64'(0));
    bus.drd_clr = 4'b0000;

`ifdef TEMP_CALC_AVG_EN
    do_reset();
    send(3'd1, 32'd16, 8'd0, 16'd0, hs);
    wait_result(re, t, c);
    check("avg_first", 64'(t), 64'(16));
    send(3'd3, 32'd100, 8'd16, 16'd16, hs);
    wait_result(re, t, c);
    check("avg_other_ch", 64'(t), 64'(116));
    send(3'd1, 32'd32, 8'd0, 16'd0, hs);
    wait_result(re, t, c);
    check("avg_second", 64'(t), 64'(24));
`endif

    // Randomized traffic, including invalid channels and random clears.
    for (int i = 0; i < 60; i++) begin
      bus.drd_clr = 4'($urandom_range(0, 15));
      send(3'($urandom_range(0, 5)), $urandom(), 8'($urandom()), 16'($urandom()), hs);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i % 20 == 19) do_reset();
    end
    bus.drd_clr = '0;
    repeat (14) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/temp_calc_mc.md
# temp_calc_mc

Multi-channel, time-multiplexed successor to the single-channel temperature calculator in the smart-house sensor path. It accepts per-channel ADC samples with calibration operands over a valid/ready handshake. For each sample it computes `tempc = tc_base + ((adc_data * tc_ref) >> FRAC)` with a sequential shift-add multiplier and publishes the result tagged with its channel. It keeps sticky per-channel data-ready (`drd`) flags for the house controller.

## Interface
- `CH`, 4: number of sensor channels (≥1)
- `CH_W`, 2: channel index width, ≥ clog2(CH)
- `ADC_W`, 16: ADC sample width
- `REF_W`, 8: calibration multiplier width; also the multiply iteration count
- `OUT_W`, 32: base and result width
- `FRAC`, 4: fractional bits dropped from the product
- `clk` in 1: clock. One clock domain; all logic is clocked on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `in_valid` in 1: sample offered
- `in_ready` out 1: block idle, can accept
- `in_ch` in CH_W: channel of offered sample
- `tc_base` in OUT_W: unsigned base offset
- `tc_ref` in REF_W: unsigned multiplier
- `adc_data` in ADC_W: unsigned ADC sample
- `out_valid` out 1: one-cycle result strobe
- `out_ch` out CH_W: channel of result
- `tempc` out OUT_W: result
- `drd` out CH: sticky per-channel data-ready flags
- `drd_clr` in CH: per-bit clear of `drd`

## Operation
- FSM states: IDLE, MUL, ADD. `in_ready` = 1 only in IDLE.
- IDLE
  - A handshake is `in_valid & in_ready` at an edge.
  - On a handshake with `in_ch < CH`, latch all operands and `in_ch`, clear the accumulator, and go to MUL.
  - On a handshake with `in_ch >= CH`, the sample is consumed and discarded. The FSM stays in IDLE, `out_valid` stays 0, and `drd` is unchanged.
- MUL
  - Runs exactly REF_W cycles, one `tc_ref` bit per cycle, LSB first.
  - Each cycle adds the shifted `adc_data` to a (ADC_W+REF_W)-bit accumulator when the current bit is 1.
  - No early exit: `tc_ref = 0` still takes REF_W cycles.
  - After the last iteration, go to ADD.
- ADD
  - raw = (tc_base + (product >> FRAC)) mod 2^OUT_W; overflow wraps, no saturation.
  - Register `tempc`, `out_ch` and `out_valid` = 1, then go to IDLE.
- `out_valid` is a single-cycle pulse with no backpressure. `tempc` and `out_ch` hold their values until the next result.
- `drd`
  - Bit `out_ch` is set on the edge that raises `out_valid`.
  - Bit i is cleared on an edge where `drd_clr[i]` = 1.
  - When set and clear hit the same bit on the same edge, set wins.
- Reset values: `in_ready` 1, `out_valid` 0, `out_ch` 0, `tempc` 0, `drd` 0, FSM in IDLE. History state as described under Configuration.
- Reset asserted mid-MUL or mid-ADD aborts the computation. No `out_valid` is produced and `drd` clears.

## Timing
- Operands are sampled only at the handshake edge. Inputs may change freely afterwards.
- `out_valid` goes high REF_W+1 edges after the handshake edge. With REF_W=8 that is 9 edges.
- `in_ready` returns to 1 in the same cycle `out_valid` is high. Back-to-back throughput is one sample per REF_W+2 cycles.
- `in_valid` held high while busy is not consumed. The sample is taken at the first edge where `in_ready` = 1.

## Configuration
- Macro: `TEMP_CALC_AVG_EN`.
- Defined:
  - Per-channel history registers `hist[CH]` (OUT_W bits each) and a valid bit per channel.
  - In ADD, `tempc` = hist_vld ? (hist + raw) >> 1 : raw. The sum is computed in OUT_W+1 bits, so it does not wrap.
  - `hist` ← raw (the un-averaged value) and hist_vld ← 1.
  - `rst` clears all hist_vld bits. No added latency.
- Undefined: no history storage; `tempc` = raw.

## Test plan
- Default parameters. Reset, then ch0 with `tc_base`=8, `tc_ref`=16, `adc_data`=8 → 9 edges later `out_valid` pulses with `tempc`=16, `out_ch`=0, `drd`=4'b0001.
- Wrap: ch2 with `tc_base`=0xFFFFFFF0, `tc_ref`=0xFF, `adc_data`=0xFFFF → `tempc`=0x000FEFE0, `drd[2]`=1.
- Backpressure: hold `in_valid` with ch1 during a busy period → `in_ready`=0 for 9 cycles. The ch1 sample is accepted on the first ready edge, and exactly two `out_valid` pulses occur.
- Reset 4 edges into MUL → no `out_valid`; `in_ready`=1 and `drd`=0 the cycle after reset. Also `in_ch`=5 with CH=4 → consumed, no result.
- `drd_clr`=4'b0001 on the same edge `drd[0]` is set → `drd[0]` stays 1. Clearing on the next edge → `drd[0]`=0.
- `TEMP_CALC_AVG_EN`: ch1 raw 16, then ch1 raw 32 → `tempc` 16, then 24. An intervening ch3 sample does not affect the ch1 history.
